// File: rtl/rnn_cell.sv
// rnn_cell: scalar fixed-point Elman RNN step engine.
// One step per rising edge of datafeed_en:
//   h_t  = hardtanh(w_x*x + w_h*h_{t-1} + b_h), clipped to [-1.0, +1.0]
//   yhat = sat(w_y*h_t + b_y), saturated to the DATA_WIDTH signed range
// A single shared signed multiplier is sequenced by the FSM
// IDLE -> MUL_X -> MUL_H -> ACT -> MUL_Y -> DONE -> IDLE.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   datafeed_en         upstream level; its rising edge starts one step
//   data_in             sample x, stable while datafeed_en is high
//   w_x,w_h,b_h,w_y,b_y coefficients, sampled when used
//   clear_state         zero hidden state and step count (deferred if busy)
//   yhat_valid, yhat    one-cycle result pulse, held prediction
//   h_out               current hidden state
//   busy                step in progress
//   sat_flag            pulses with yhat_valid when yhat was clamped
//   step_cnt            completed steps since reset/clear (wraps)
module rnn_cell #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned CNT_WIDTH  = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         datafeed_en,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic signed [DATA_WIDTH-1:0] w_x,
    input  logic signed [DATA_WIDTH-1:0] w_h,
    input  logic signed [DATA_WIDTH-1:0] b_h,
    input  logic signed [DATA_WIDTH-1:0] w_y,
    input  logic signed [DATA_WIDTH-1:0] b_y,
    input  logic                         clear_state,
    output logic                         yhat_valid,
    output logic signed [DATA_WIDTH-1:0] yhat,
    output logic signed [DATA_WIDTH-1:0] h_out,
    output logic                         busy,
    output logic                         sat_flag,
    output logic        [CNT_WIDTH-1:0]  step_cnt
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned AW = 2 * DATA_WIDTH + 2;

    // Hardtanh bounds (+/-1.0) and output saturation bounds in accumulator width.
    localparam logic signed [AW-1:0] H_HI = AW'(1) <<< FRAC_BITS;
    localparam logic signed [AW-1:0] H_LO = -H_HI;
    localparam logic signed [AW-1:0] Y_HI = (AW'(1) <<< (DATA_WIDTH - 1)) - AW'(1);
    localparam logic signed [AW-1:0] Y_LO = -(AW'(1) <<< (DATA_WIDTH - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_X,
        S_MUL_H,
        S_ACT,
        S_MUL_Y,
        S_DONE
    } state_t;

    state_t                        state;
    logic                          fe_q;
    logic                          clr_pend;
    logic signed [DATA_WIDTH-1:0]  x_q;
    logic signed [AW-1:0]          acc;

    logic                          start_c;
    logic signed [DATA_WIDTH-1:0]  mul_a_c;
    logic signed [DATA_WIDTH-1:0]  mul_b_c;
    logic signed [DATA_WIDTH-1:0]  bias_c;
    logic signed [PW-1:0]          prod_c;
    logic signed [AW-1:0]          term_c;
    logic signed [AW-1:0]          base_c;
    logic signed [AW-1:0]          sum_c;

    assign start_c = (state == S_IDLE) && datafeed_en && !fe_q;

    // Shared multiply-accumulate: operand and addend selection by state.
    always_comb begin
        mul_a_c = w_x;
        mul_b_c = x_q;
        bias_c  = b_h;
        case (state)
            S_MUL_H: begin
                mul_a_c = w_h;
                mul_b_c = h_out;
            end
            S_MUL_Y: begin
                mul_a_c = w_y;
                mul_b_c = h_out;
                bias_c  = b_y;
            end
            default: ;
        endcase
        prod_c = PW'(mul_a_c) * PW'(mul_b_c);
        // Arithmetic shift floors toward -inf.
        term_c = AW'(prod_c >>> FRAC_BITS);
        base_c = (state == S_MUL_H) ? acc : AW'(bias_c);
        sum_c  = base_c + term_c;
    end

    // Step sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            fe_q       <= 1'b0;
            clr_pend   <= 1'b0;
            x_q        <= '0;
            acc        <= '0;
            yhat_valid <= 1'b0;
            yhat       <= '0;
            h_out      <= '0;
            busy       <= 1'b0;
            sat_flag   <= 1'b0;
            step_cnt   <= '0;
        end else begin
            fe_q       <= datafeed_en;
            yhat_valid <= 1'b0;
            sat_flag   <= 1'b0;
            busy       <= start_c || (state != S_IDLE);

            // A clear during a step is deferred until the step retires.
            if (clear_state && (state != S_IDLE) && (state != S_DONE)) begin
                clr_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_c) begin
                        x_q   <= data_in;
                        state <= S_MUL_X;
                        if (clear_state) begin
                            clr_pend <= 1'b1;
                        end
                    end else if (clear_state) begin
                        h_out    <= '0;
                        step_cnt <= '0;
                    end
                end
                S_MUL_X: begin
                    acc   <= sum_c;
                    state <= S_MUL_H;
                end
                S_MUL_H: begin
                    acc   <= sum_c;
                    state <= S_ACT;
                end
                S_ACT: begin
                    if (acc > H_HI) begin
                        h_out <= DATA_WIDTH'(H_HI);
                    end else if (acc < H_LO) begin
                        h_out <= DATA_WIDTH'(H_LO);
                    end else begin
                        h_out <= DATA_WIDTH'(acc);
                    end
                    state <= S_MUL_Y;
                end
                S_MUL_Y: begin
                    acc   <= sum_c;
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (acc > Y_HI) begin
                        yhat     <= DATA_WIDTH'(Y_HI);
                        sat_flag <= 1'b1;
                    end else if (acc < Y_LO) begin
                        yhat     <= DATA_WIDTH'(Y_LO);
                        sat_flag <= 1'b1;
                    end else begin
                        yhat <= DATA_WIDTH'(acc);
                    end
                    yhat_valid <= 1'b1;
                    state      <= S_IDLE;
                    // Pending clear wins over this step's count increment.
                    if (clr_pend || clear_state) begin
                        h_out    <= '0;
                        step_cnt <= '0;
                        clr_pend <= 1'b0;
                    end else begin
                        step_cnt <= step_cnt + CNT_WIDTH'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rnn_cell.sv
// Scoreboard bench for rnn_cell: the driver pushes hand-computed expectations
// per step, the monitor pops and compares on every yhat_valid pulse.
module tb_rnn_cell;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 9;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 datafeed_en;
    logic signed [DW-1:0] data_in;
    logic signed [DW-1:0] w_x, w_h, b_h, w_y, b_y;
    logic                 clear_state;
    logic                 yhat_valid;
    logic signed [DW-1:0] yhat;
    logic signed [DW-1:0] h_out;
    logic                 busy;
    logic                 sat_flag;
    logic [CW-1:0]        step_cnt;

    typedef struct {
        logic signed [DW-1:0] yhat;
        logic                 sat;
        logic signed [DW-1:0] h;
        int                   cnt;
        int                   start;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   cyc    = 0;
    bit   prev_v = 1'b0;

    rnn_cell #(.DATA_WIDTH(DW), .FRAC_BITS(8), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .datafeed_en(datafeed_en),
        .data_in    (data_in),
        .w_x        (w_x),
        .w_h        (w_h),
        .b_h        (b_h),
        .w_y        (w_y),
        .b_y        (b_y),
        .clear_state(clear_state),
        .yhat_valid (yhat_valid),
        .yhat       (yhat),
        .h_out      (h_out),
        .busy       (busy),
        .sat_flag   (sat_flag),
        .step_cnt   (step_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: pulse-width check and scoreboard pop on every valid.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_v) begin
                chk("pulse_width", int'({yhat_valid, sat_flag}), 0);
            end
            prev_v = yhat_valid;
            if (yhat_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_valid: yhat=%0d with no step outstanding", yhat);
                end else begin
                    e = exp_q.pop_front();
                    chk("yhat", int'(yhat), int'(e.yhat));
                    chk("sat_flag", int'(sat_flag), int'(e.sat));
                    chk("h_out", int'(h_out), int'(e.h));
                    chk("step_cnt", int'(step_cnt), e.cnt);
                    // First rising edge that samples yhat_valid high, counted from the start edge.
                    chk("latency", cyc + 1 - e.start, 6);
                end
            end
        end
    end

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (yhat_valid) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: no yhat_valid within 20 cycles");
        end
    endtask

    task automatic push_exp(input logic signed [DW-1:0] ey, input logic es,
                            input logic signed [DW-1:0] eh, input int ecnt, input int st);
        exp_t e;
        e.yhat  = ey;
        e.sat   = es;
        e.h     = eh;
        e.cnt   = ecnt;
        e.start = st;
        exp_q.push_back(e);
    endtask

    task automatic do_step(input logic signed [DW-1:0] x, input logic signed [DW-1:0] ey,
                           input logic es, input logic signed [DW-1:0] eh, input int ecnt,
                           input int hold, input bit clr_mid);
        int e0;
        @(negedge clk);
        data_in     = x;
        datafeed_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        e0 = cyc;
        push_exp(ey, es, eh, ecnt, e0);
        if (clr_mid) begin
            // Sampled on the MUL_H edge (cycle 2).
            @(negedge clk);
            clear_state = 1'b1;
            @(negedge clk);
            clear_state = 1'b0;
        end
        wait_valid();
        repeat (hold) @(negedge clk);
        datafeed_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_coef(input int ax, input int ah, input int bh, input int ay, input int by);
        w_x = DW'(ax);
        w_h = DW'(ah);
        b_h = DW'(bh);
        w_y = DW'(ay);
        b_y = DW'(by);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int e0;
        rst         = 1'b1;
        datafeed_en = 1'b0;
        data_in     = '0;
        clear_state = 1'b0;
        set_coef(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_yhat", int'(yhat), 0);
        chk("rst_valid", int'(yhat_valid), 0);
        chk("rst_h", int'(h_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sat", int'(sat_flag), 0);
        chk("rst_cnt", int'(step_cnt), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Identity.
        set_coef(256, 0, 0, 256, 0);
        do_step(16'sd128, 16'sd128, 1'b0, 16'sd128, 1, 1, 1'b0);

        // Clear in IDLE.
        clear_state = 1'b1;
        @(negedge clk);
        clear_state = 1'b0;
        chk("idle_clear_h", int'(h_out), 0);
        chk("idle_clear_cnt", int'(step_cnt), 0);

        // Recurrence.
        set_coef(256, 128, 0, 256, 0);
        do_step(16'sd256, 16'sd256, 1'b0, 16'sd256, 1, 1, 1'b0);
        do_step(16'sd0, 16'sd128, 1'b0, 16'sd128, 2, 1, 1'b0);

        // Hardtanh clip and floor truncation.
        set_coef(1024, 0, 0, 256, 0);
        do_step(16'sd256, 16'sd256, 1'b0, 16'sd256, 3, 1, 1'b0);
        set_coef(128, 0, 0, 256, 0);
        do_step(-16'sd1, -16'sd1, 1'b0, -16'sd1, 4, 1, 1'b0);

        // Output saturation, both rails.
        set_coef(256, 0, 0, 32767, 32767);
        do_step(16'sd256, 16'sd32767, 1'b1, 16'sd256, 5, 1, 1'b0);
        set_coef(256, 0, 0, -32768, -32768);
        do_step(16'sd256, -16'sd32768, 1'b1, 16'sd256, 6, 1, 1'b0);

        // Handshake: long hold yields one step, fresh edge yields the next.
        set_coef(256, 0, 0, 256, 0);
        do_step(16'sd64, 16'sd64, 1'b0, 16'sd64, 7, 3, 1'b0);
        chk("hold_idle_busy", int'(busy), 0);
        do_step(16'sd32, 16'sd32, 1'b0, 16'sd32, 8, 1, 1'b0);

        // Clear mid-step: yhat uses old h=32 (16+32=48), then state zeroed.
        set_coef(256, 256, 0, 256, 0);
        do_step(16'sd16, 16'sd48, 1'b0, 16'sd0, 0, 1, 1'b1);
        do_step(16'sd100, 16'sd100, 1'b0, 16'sd100, 1, 1, 1'b0);

        // Reset during MUL_H, restart with datafeed_en still high.
        @(negedge clk);
        data_in     = 16'sd50;
        datafeed_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_yhat", int'(yhat), 0);
        chk("midrst_valid", int'(yhat_valid), 0);
        chk("midrst_h", int'(h_out), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_sat", int'(sat_flag), 0);
        chk("midrst_cnt", int'(step_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        e0 = cyc;
        push_exp(16'sd50, 1'b0, 16'sd50, 1, e0);
        wait_valid();
        @(negedge clk);
        datafeed_en = 1'b0;

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rnn_cell.md
# rnn_cell

Scalar fixed-point Elman RNN step engine sitting directly downstream of the input sample SRAM. The engine waits for the SRAM controller to raise `datafeed_en` and then takes one sample `x`. It computes the hidden state h_t = hardtanh(w_x·x + w_h·h_{t−1} + b_h) and the prediction yhat = sat(w_y·h_t + b_y). It returns a one-cycle `yhat_valid` pulse, which advances the SRAM controller to its next address. One shared signed multiplier is sequenced by an FSM; the hidden state persists across samples until cleared.

## Interface
- DATA_WIDTH, 16: width of samples, weights, biases, h, yhat (signed two's complement).
- FRAC_BITS, 8: fractional bits (default Q8.8; 1.0 = 256).
- CNT_WIDTH, 9: width of step counter.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- datafeed_en  in  1  level from SRAM controller; a rising edge starts one step.
- data_in  in  DATA_WIDTH  sample x; valid and stable while datafeed_en high.
- w_x, w_h, b_h, w_y, b_y  in  DATA_WIDTH each  coefficients; quasi-static, sampled when used.
- clear_state  in  1  zero hidden state and step count.
- yhat_valid  out  1  one-cycle pulse, yhat valid.
- yhat  out  DATA_WIDTH  prediction, held until next step.
- h_out  out  DATA_WIDTH  current hidden state.
- busy  out  1  high from start detection until the DONE cycle inclusive.
- sat_flag  out  1  one-cycle pulse with yhat_valid if yhat was saturated.
- step_cnt  out  CNT_WIDTH  completed steps since reset/clear, wraps modulo 2^CNT_WIDTH.

## Operation
- Reset values: all outputs 0, hidden state 0, FSM IDLE, edge register `fe_q` 0, pending clear 0.
- Start: in IDLE, when datafeed_en=1 and fe_q=0, latch x<=data_in and go to MUL_X. fe_q<=datafeed_en every cycle.
- After reset, if datafeed_en is already high, a step starts on the first clock.
- FSM states: IDLE → MUL_X → MUL_H → ACT → MUL_Y → DONE → IDLE. Every non-IDLE state lasts exactly one cycle.
  - MUL_X: acc <= sext(b_h) + (w_x·x >>> FRAC_BITS).
  - MUL_H: acc <= acc + (w_h·h >>> FRAC_BITS).
  - ACT: h <= clip(acc, −2^FRAC_BITS, +2^FRAC_BITS), i.e. [−256, 256] by default.
  - MUL_Y: acc <= sext(b_y) + (w_y·h >>> FRAC_BITS), using the new h.
  - DONE: yhat <= saturate acc to [−2^(DW−1), 2^(DW−1)−1]; yhat_valid=1; sat_flag=1 if clamped; step_cnt+1.
- Arithmetic:
  - Products are 2·DATA_WIDTH signed.
  - `>>>` is an arithmetic shift, truncating toward −∞.
  - acc is 2·DATA_WIDTH+2 bits signed, so no internal wrap.
  - Only the clip in ACT and the saturation in DONE narrow the width.
- Rising edges of datafeed_en while busy are ignored. The upstream holds datafeed_en high until it sees yhat_valid and drops it ≥1 cycle later, so the next step needs a fresh rising edge.
- clear_state:
  - In IDLE with no start that cycle: h<=0 and step_cnt<=0 next cycle.
  - If it coincides with a start, or arrives while busy: set pending. The step completes normally with the old h; h and step_cnt are zeroed on the DONE→IDLE transition, overriding DONE's increment. yhat_valid still pulses.
- rst mid-step: FSM to IDLE immediately, no yhat_valid, h=0.

## Timing
- Cycle 0 = first edge where datafeed_en is sampled 1 with fe_q=0 (start).
- States by cycle: MUL_X 1, MUL_H 2, ACT 3, MUL_Y 4, DONE 5.
- yhat, yhat_valid and sat_flag are registered and visible in cycle 6, i.e. a 6-cycle start-to-valid latency.
- yhat_valid is high for exactly 1 cycle.
- The next start is accepted no earlier than cycle 6.
- h_out updates in the cycle after ACT.
- busy is high from cycle 1 through cycle 6 inclusive.

## Test plan
- Identity:
  - Stimulus: w_x=256, w_y=256, w_h=b_h=b_y=0; x=128.
  - Response: yhat=128, yhat_valid exactly 6 cycles after start, single-cycle pulse, step_cnt=1.
- Recurrence:
  - Stimulus: w_x=256, w_h=128, w_y=256, biases 0; x sequence 256, 0.
  - Response: yhat 256 then 128; h_out 256 then 128.
- Clip and truncation:
  - Stimulus: w_x=1024, x=256.
  - Response: h=256, yhat=256.
  - Stimulus: w_x=128, x=−1.
  - Response: h=−1, yhat=−1 (floor, not toward zero).
- Saturation:
  - Stimulus: w_x=256, x=256, w_y=32767, b_y=32767.
  - Response: yhat=32767, sat_flag pulses with yhat_valid.
  - Stimulus: b_y=−32768, w_y=−32768.
  - Response: yhat=−32768, sat_flag pulses.
- Handshake:
  - Hold datafeed_en high 3 cycles past yhat_valid → exactly one step.
  - Drop datafeed_en 2 cycles, re-raise → second step.
  - clear_state asserted at cycle 2 of a step → yhat from old h, then h_out=0, step_cnt=0.
- Reset mid-op:
  - Stimulus: assert rst during MUL_H.
  - Response: no yhat_valid; all outputs 0 asynchronously.
  - With datafeed_en still high at release → new step starts on first clock.
